// File: rtl/led_pattern_driver.sv
// led_pattern_driver: board LED pattern generator (off / solid / blink / PWM breathe).
// A prescaled step tick advances the blink toggle and the breathe duty ramp;
// a free-running PWM frame counter turns the latched duty into LED on-time.
// Optional build macro LED_GAMMA_EN: squares the duty at frame latch so the
// breathe ramp looks perceptually linear.
module led_pattern_driver #(
    parameter int PRESCALE = 50000,
    parameter int PWM_BITS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] MODE,
    output logic       LED0,
    output logic       STEP_TICK,
    output logic       PHASE_UP
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_SOLID   = 2'b01;
    localparam logic [1:0] M_BLINK   = 2'b10;
    localparam logic [1:0] M_BREATHE = 2'b11;

    typedef enum logic {S_DOWN = 1'b0, S_UP = 1'b1} phase_t;

    phase_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [PWM_BITS-1:0] r_duty_act, w_duty_act_nxt;
    logic                r_blink_q;
    logic [1:0]          r_mode_q;
    logic                r_led;
    logic                r_step_tick;
    logic                w_restart;
    logic                w_step;
    logic                w_frame_end;

    // Dropping EN or switching pattern restarts everything from a clean state,
    // so a new pattern always begins at its first step.
    assign w_restart   = !EN || (MODE != r_mode_q);
    assign w_step      = (r_pre_cnt == PRE_LAST);
    assign w_frame_end = (r_pwm_cnt == MAX);

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq           = {{PWM_BITS{1'b0}}, w_duty_nxt} * {{PWM_BITS{1'b0}}, w_duty_nxt};
    assign w_duty_act_nxt = PWM_BITS'(w_sq >> PWM_BITS);
`else
    assign w_duty_act_nxt = w_duty_nxt;
`endif

    // Breathe ramp: next duty and direction; turning points keep duty in 0..MAX.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        if (w_restart || r_mode_q != M_BREATHE) begin
            w_state_nxt = S_UP;
            w_duty_nxt  = '0;
        end else if (w_step) begin
            case (r_state)
                S_UP: begin
                    w_duty_nxt = r_duty + 1'b1;
                    if (w_duty_nxt == MAX) w_state_nxt = S_DOWN;
                end
                default: begin
                    w_duty_nxt = r_duty - 1'b1;
                    if (w_duty_nxt == '0) w_state_nxt = S_UP;
                end
            endcase
        end
    end

    // Breathe state and duty registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_UP;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    // Prescaler, PWM frame counter, frame-aligned duty latch, blink and LED drive.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= '0;
            r_duty_act  <= '0;
            r_blink_q   <= 1'b0;
            r_mode_q    <= M_OFF;
            r_led       <= 1'b0;
            r_step_tick <= 1'b0;
        end else begin
            r_mode_q <= MODE;
            if (w_restart) begin
                r_pre_cnt   <= '0;
                r_pwm_cnt   <= '0;
                r_duty_act  <= '0;
                r_blink_q   <= 1'b0;
                r_led       <= 1'b0;
                r_step_tick <= 1'b0;
            end else begin
                r_pre_cnt   <= w_step ? '0 : r_pre_cnt + 1'b1;
                r_pwm_cnt   <= r_pwm_cnt + 1'b1;
                r_step_tick <= w_step;
                // Duty only changes between frames, so no frame is ever cut short.
                if (w_frame_end) r_duty_act <= w_duty_act_nxt;
                if (w_step && r_mode_q == M_BLINK) r_blink_q <= ~r_blink_q;
                case (r_mode_q)
                    M_OFF:   r_led <= 1'b0;
                    M_SOLID: r_led <= 1'b1;
                    M_BLINK: r_led <= r_blink_q;
                    default: r_led <= (r_pwm_cnt < r_duty_act);
                endcase
            end
        end
    end

    assign LED0      = r_led;
    assign STEP_TICK = r_step_tick;
    assign PHASE_UP  = (r_state == S_UP);

endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver: checks led_pattern_driver (PRESCALE=8, PWM_BITS=3)
// against a closed-form model indexed by edges since the last restart.
// Build with LED_GAMMA_EN defined to check the gamma-corrected variant.
module tb_led_pattern_driver;

    localparam int P  = 8;
    localparam int NB = 3;
    localparam int F  = 1 << NB;
    localparam int MX = F - 1;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b0;
    logic       EN   = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic       LED0, STEP_TICK, PHASE_UP;

    int         total = 0;
    int         bad   = 0;
    int         n     = 0;       // clean edges since last restart edge
    logic [1:0] mq    = 2'b00;   // model of the registered mode

    led_pattern_driver #(.PRESCALE(P), .PWM_BITS(NB)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
        .LED0(LED0), .STEP_TICK(STEP_TICK), .PHASE_UP(PHASE_UP)
    );

    always #5 CLK = ~CLK;

    // duty after s steps: triangle 0..MX..1 repeating
    function automatic int tri_f(input int s);
        int r;
        r = s % (2 * MX);
        return (r <= MX) ? r : 2 * MX - r;
    endfunction

    function automatic int gam(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) >> NB;
`else
        return d;
`endif
    endfunction

    function automatic logic exp_led(input int en, input logic [1:0] m);
        int k, da;
        if (en == 0) return 1'b0;
        k = en - 1;
        case (m)
            2'd0: return 1'b0;
            2'd1: return 1'b1;
            2'd2: return ((k / P) % 2) == 1;
            default: begin
                da = (k < F) ? 0 : gam(tri_f(((k / F) * F) / P));
                return (k % F) < da;
            end
        endcase
    endfunction

    function automatic logic exp_step(input int en);
        return (en > 0) && (en % P == 0);
    endfunction

    function automatic logic exp_ph(input int en, input logic [1:0] m);
        if (m != 2'd3) return 1'b1;
        return ((en / P) % (2 * MX)) < MX;
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            n = 0; mq = 2'b00;
        end else begin
            if (!EN || MODE != mq) n = 0; else n++;
            mq = MODE;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        total++;
        if ({LED0, STEP_TICK, PHASE_UP} !== 3'b001) begin
            bad++; $display("FAIL reset_async got=%b want=001", {LED0, STEP_TICK, PHASE_UP});
        end
        repeat (3) begin
            tick();
            total++;
            if ({LED0, STEP_TICK, PHASE_UP} !== 3'b001) begin
                bad++; $display("FAIL reset_hold got=%b want=001", {LED0, STEP_TICK, PHASE_UP});
            end
        end
        @(negedge CLK) RST = 1'b0;
    endtask

    task automatic test_solid();
        logic e;
        EN = 1'b1; MODE = 2'd1;
        repeat (24) begin
            tick();
            e = exp_led(n, mq); total++;
            if (LED0 !== e) begin bad++; $display("FAIL solid_led n=%0d got=%b want=%b", n, LED0, e); end
            e = exp_step(n); total++;
            if (STEP_TICK !== e) begin bad++; $display("FAIL solid_tick n=%0d got=%b want=%b", n, STEP_TICK, e); end
        end
    endtask

    task automatic test_blink();
        logic e;
        MODE = 2'd2;
        repeat (40) begin
            tick();
            e = exp_led(n, mq); total++;
            if (LED0 !== e) begin bad++; $display("FAIL blink_led n=%0d got=%b want=%b", n, LED0, e); end
            e = exp_step(n); total++;
            if (STEP_TICK !== e) begin bad++; $display("FAIL blink_tick n=%0d got=%b want=%b", n, STEP_TICK, e); end
        end
    endtask

    task automatic test_breathe();
`ifdef LED_GAMMA_EN
        int tbl[16] = '{0,0,0,1,2,3,4,6,4,3,2,1,0,0,0,0};
`else
        int tbl[16] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
`endif
        int   cnt;
        logic e;
        MODE = 2'd3;
        tick();   // restart edge for the mode change
        for (int j = 0; j < 16; j++) begin
            cnt = 0;
            repeat (F) begin
                tick();
                cnt += int'(LED0);
                e = exp_ph(n, mq); total++;
                if (PHASE_UP !== e) begin bad++; $display("FAIL breathe_phase n=%0d got=%b want=%b", n, PHASE_UP, e); end
            end
            total++;
            if (cnt != tbl[j]) begin bad++; $display("FAIL breathe_frame j=%0d got=%0d want=%0d", j, cnt, tbl[j]); end
        end
    endtask

    task automatic test_en_drop();
        logic e;
        EN = 1'b0; tick(); EN = 1'b1;
        while (n < 5 * P) tick();   // duty now 5
        EN = 1'b0; tick(); EN = 1'b1;
        total++;
        if ({LED0, STEP_TICK, PHASE_UP} !== 3'b001) begin
            bad++; $display("FAIL endrop_clear got=%b want=001", {LED0, STEP_TICK, PHASE_UP});
        end
        repeat (3 * F) begin
            tick();
            e = exp_led(n, mq); total++;
            if (LED0 !== e) begin bad++; $display("FAIL endrop_led n=%0d got=%b want=%b", n, LED0, e); end
            e = exp_ph(n, mq); total++;
            if (PHASE_UP !== e) begin bad++; $display("FAIL endrop_phase n=%0d got=%b want=%b", n, PHASE_UP, e); end
        end
    endtask

    task automatic test_async_mid();
        logic e;
        MODE = 2'd1;
        repeat (5) tick();
        total++;
        if (LED0 !== 1'b1) begin bad++; $display("FAIL async_pre got=%b want=1", LED0); end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({LED0, STEP_TICK, PHASE_UP} !== 3'b001) begin
            bad++; $display("FAIL async_mid got=%b want=001", {LED0, STEP_TICK, PHASE_UP});
        end
        @(negedge CLK) RST = 1'b0;
        n = 0; mq = 2'b00;
        repeat (6) begin
            tick();
            e = exp_led(n, mq); total++;
            if (LED0 !== e) begin bad++; $display("FAIL async_post n=%0d got=%b want=%b", n, LED0, e); end
        end
    endtask

    task automatic test_random();
        int   len;
        logic e;
        repeat (40) begin
            EN   = ($urandom_range(0, 9) != 0);
            MODE = 2'($urandom_range(0, 3));
            len  = $urandom_range(1, 60);
            repeat (len) begin
                tick();
                e = exp_led(n, mq); total++;
                if (LED0 !== e) begin bad++; $display("FAIL rand_led n=%0d m=%0d got=%b want=%b", n, mq, LED0, e); end
                e = exp_step(n); total++;
                if (STEP_TICK !== e) begin bad++; $display("FAIL rand_tick n=%0d got=%b want=%b", n, STEP_TICK, e); end
                e = exp_ph(n, mq); total++;
                if (PHASE_UP !== e) begin bad++; $display("FAIL rand_phase n=%0d m=%0d got=%b want=%b", n, mq, PHASE_UP, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_blink();
        test_breathe();
        test_en_drop();
        test_async_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
Output stage that drives the board LED from the system clock. It generates one of four visible patterns: off, solid, blink, or PWM breathing. Everything derives from a prescaled step tick and a free-running PWM frame counter. It sits directly upstream of the LED0 pin in the top-level main, replacing the bare counter-bit LED drive.

Parameters:
PRESCALE, 50000, clock cycles per step tick (>=2).
PWM_BITS, 8, PWM counter and duty width; MAX = 2^PWM_BITS-1.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  pattern enable; 0 forces LED off and restarts the sequence.
MODE  input  2  pattern select: 00 off, 01 solid, 10 blink, 11 breathe.
LED0  output  1  registered LED drive.
STEP_TICK  output  1  one-cycle pulse per completed prescale period.
PHASE_UP  output  1  breathe direction: 1 = brightening, 0 = dimming.

Behaviour:
- Clocking and reset:
  - One clock domain (CLK); RST is asynchronous and active-high.
  - RST asserted clears everything immediately, with no clock edge: LED0=0, STEP_TICK=0, PHASE_UP=1, pre_cnt=0, pwm_cnt=0, duty=0, duty_act=0, blink_q=0, mode_q=00.
- Restart condition, checked every cycle: EN=0, or MODE!=mode_q.
  - On the next edge: pre_cnt=0, pwm_cnt=0, duty=0, duty_act=0, blink_q=0, PHASE_UP=1, STEP_TICK=0, LED0=0.
  - mode_q<=MODE on every edge.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1, then wraps to 0.
  - STEP_TICK is registered: it is 1 in the cycle after pre_cnt==PRESCALE-1.
  - Internal step events use the same condition (pre_cnt==PRESCALE-1) at the same edge.
- PWM counter:
  - pwm_cnt is free-running, PWM_BITS wide, and wraps MAX->0.
  - At the edge where pwm_cnt==MAX, duty_act latches the next value of duty. If a step coincides, the updated value is latched.
  - Duty therefore changes only at frame boundaries, so frames are glitch-free.
- Modes (LED0 is registered, one cycle latency from state):
  - 00 off: LED0=0.
  - 01 solid: LED0=1.
  - 10 blink: blink_q toggles on each step; LED0=blink_q. Period is 2*PRESCALE cycles.
  - 11 breathe: LED0 = (pwm_cnt < duty_act). Duty 0 gives always off; duty MAX gives MAX of 2^PWM_BITS cycles high.
- Breathe FSM (state = PHASE_UP), acting on each step:
  - UP: duty<=duty+1; if duty+1==MAX, go to DOWN.
  - DOWN: duty<=duty-1; if duty-1==0, go to UP.
  - Step sequence: 0,1..MAX,MAX-1..1,0,1...
  - Duty never under- or overflows.
  - In modes other than 11, duty holds 0 and PHASE_UP holds 1.
- Arithmetic:
  - All counters are unsigned and wrap only as stated.
  - The comparison is PWM_BITS wide and unsigned.

Optional Feature:
LED_GAMMA_EN
- Defined: at frame latch, duty_act <= (d*d)>>PWM_BITS, where d = next duty. The multiply is 2*PWM_BITS wide, which gives perceptually linear brightness. Duty MAX maps to MAX-1 when PWM_BITS>=2.
- Undefined: duty_act <= d directly.
- STEP_TICK, PHASE_UP and the FSM are identical in both builds.

Test Plan:
- RST=1 for 3 cycles, plus a mid-run async pulse between clock edges -> LED0=0, STEP_TICK=0, PHASE_UP=1 immediately, with no edge needed.
- PRESCALE=4, EN=1, MODE=01 -> LED0=1 from the first edge after the mode-change restart cycle; STEP_TICK pulses every 4 cycles.
- PRESCALE=4, MODE=10 -> LED0 toggles on each STEP_TICK; high 4 cycles, low 4 cycles (period 8).
- PRESCALE=8, PWM_BITS=3, MODE=11, no gamma -> per-frame high counts 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1...; PHASE_UP falls after the step that reaches 7 and rises after the step that reaches 0.
- Breathe running at duty=5, EN dropped for 1 cycle -> LED0=0 next edge; sequence restarts from duty 0 with PHASE_UP=1.
- LED_GAMMA_EN, PWM_BITS=3, PRESCALE=8 -> per-frame high counts 0,0,0,1,2,3,4,6,4,3,2,1,0,0,0...
